// File: rtl/risc_v_mike_pkg.sv
// Shared types and constants for the risc_v_mike core slice.
//   t_pc_addr        : 32-bit byte address used by the fetch stage
//   RV_NOP           : canonical RISC-V NOP (addi x0, x0, 0)
//   IMEM_DEPTH_DEF   : default instruction-memory depth in 32-bit words
//   t_imem_ld_state  : instruction-memory loader FSM states
package risc_v_mike_pkg;

  typedef logic [31:0] t_pc_addr;

  localparam logic [31:0] RV_NOP = 32'h00000013;
  localparam int IMEM_DEPTH_DEF = 1024;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_RX,
    LD_WR,
    LD_DONE
  } t_imem_ld_state;

endpackage

// File: rtl/risc_v_mike_byte_packer.sv
// Packs a byte stream into little-endian 32-bit words.
//   clk, rst   : clock, synchronous active-high reset (clears count and word)
//   clear      : restart packing at byte 0 (word contents are overwritten anyway)
//   byte_en    : a byte is accepted this cycle
//   byte_data  : accepted byte; byte n of a word lands in bits [8n+7:8n]
//   word_full  : the byte accepted this cycle completes the word
//   word       : packed word register
module risc_v_mike_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic        word_full,
  output logic [31:0] word
);

  logic [1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= 2'd0;
      word <= 32'd0;
    end else if (clear) begin
      cnt <= 2'd0;
    end else if (byte_en) begin
      word[{cnt, 3'b000} +: 8] <= byte_data;
      cnt                      <= cnt + 2'd1;
    end
  end

  assign word_full = byte_en && (cnt == 2'd3);

endmodule

// File: rtl/risc_v_mike_imem_loader.sv
// Instruction-memory loader: owns the imem write port, receives a program as
// a byte stream, packs it into words and writes them to consecutive word
// addresses starting at 0, while holding the core and feeding it NOPs.
//   load_start/load_len          : begin a load of load_len words (IDLE only)
//   byte_valid/byte_data/ready   : byte-stream handshake from the source
//   fetch_addr/fetch_data        : core fetch path (byte PC in, instruction out)
//   imem_rd_addr/imem_rd_data    : combinational memory read port
//   imem_wr_en/addr/data         : memory write port, driven only in WR
//   core_hold                    : stall the PC while a load is in progress
//   load_done                    : one-cycle pulse when the last word is written
//   load_err                     : sticky, set by an illegal load_len
//   fetch_err                    : misaligned or out-of-range fetch address
module risc_v_mike_imem_loader
  import risc_v_mike_pkg::*;
#(
  parameter int IMEM_DEPTH  = IMEM_DEPTH_DEF,
  parameter int IMEM_ADDR_W = $clog2(IMEM_DEPTH),
  parameter int LEN_W       = IMEM_ADDR_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_start,
  input  logic [LEN_W-1:0]       load_len,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  output logic                   byte_ready,
  input  t_pc_addr               fetch_addr,
  output logic [31:0]            fetch_data,
  output logic [IMEM_ADDR_W-1:0] imem_rd_addr,
  input  logic [31:0]            imem_rd_data,
  output logic                   imem_wr_en,
  output logic [IMEM_ADDR_W-1:0] imem_wr_addr,
  output logic [31:0]            imem_wr_data,
  output logic                   core_hold,
  output logic                   load_done,
  output logic                   load_err,
  output logic                   fetch_err
);

  localparam logic [LEN_W-1:0] DEPTH_LEN  = LEN_W'(IMEM_DEPTH);
  localparam logic [31:0]      DEPTH_WORD = 32'(IMEM_DEPTH);

  t_imem_ld_state   state, state_next;
  logic [LEN_W-1:0] len_lat;
  logic [LEN_W-1:0] word_ptr;
  logic [LEN_W-1:0] ptr_inc;
  logic             len_ok;
  logic             byte_acc;
  logic             word_full;
  logic [31:0]      packed_word;

  // word_ptr is LEN_W wide so that a full-depth load ends with ptr_inc equal
  // to IMEM_DEPTH instead of wrapping to zero.
  assign ptr_inc  = word_ptr + LEN_W'(1);
  assign len_ok   = (load_len != '0) && (load_len <= DEPTH_LEN);
  assign byte_acc = byte_valid && byte_ready;

  risc_v_mike_byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (state == LD_WR),
    .byte_en   (byte_acc),
    .byte_data (byte_data),
    .word_full (word_full),
    .word      (packed_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LD_IDLE;
      len_lat  <= '0;
      word_ptr <= '0;
      load_err <= 1'b0;
    end else begin
      state <= state_next;
      if (state == LD_IDLE && load_start) begin
        if (len_ok) begin
          load_err <= 1'b0;
          len_lat  <= load_len;
          word_ptr <= '0;
        end else begin
          load_err <= 1'b1;
        end
      end
      if (state == LD_WR) begin
        word_ptr <= ptr_inc;
      end
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      LD_IDLE: if (load_start && len_ok) state_next = LD_RX;
      LD_RX:   if (word_full) state_next = LD_WR;
      LD_WR:   state_next = (ptr_inc == len_lat) ? LD_DONE : LD_RX;
      LD_DONE: state_next = LD_IDLE;
      default: state_next = LD_IDLE;
    endcase
  end

  assign byte_ready   = (state == LD_RX);
  assign imem_wr_en   = (state == LD_WR);
  assign imem_wr_addr = word_ptr[IMEM_ADDR_W-1:0];
  assign imem_wr_data = packed_word;
  assign core_hold    = (state != LD_IDLE);
  assign load_done    = (state == LD_DONE);

  // Fetch path: the core sees NOPs while held or when its PC is unusable.
  assign imem_rd_addr = fetch_addr[IMEM_ADDR_W+1:2];
  assign fetch_err    = (fetch_addr[1:0] != 2'b00) || ((fetch_addr >> 2) >= DEPTH_WORD);
  assign fetch_data   = (core_hold || fetch_err) ? RV_NOP : imem_rd_data;

endmodule

// File: tb/tb_risc_v_mike_imem_loader.sv
module tb_risc_v_mike_imem_loader;

  localparam int DEPTH  = 1024;
  localparam int AW     = 10;
  localparam int LW     = 11;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] FILL = 32'hdeadbeef;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic [LW-1:0] load_len;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic [31:0]   fetch_addr;
  logic [31:0]   fetch_data;
  logic [AW-1:0] imem_rd_addr;
  logic [31:0]   imem_rd_data;
  logic          imem_wr_en;
  logic [AW-1:0] imem_wr_addr;
  logic [31:0]   imem_wr_data;
  logic          core_hold;
  logic          load_done;
  logic          load_err;
  logic          fetch_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wa [$];
  logic [31:0]   wd [$];
  logic [7:0]    src [16];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } fvec_t;
  fvec_t fv [7];

  always #5 clk = ~clk;

  risc_v_mike_imem_loader #(.IMEM_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .load_len     (load_len),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .fetch_addr   (fetch_addr),
    .fetch_data   (fetch_data),
    .imem_rd_addr (imem_rd_addr),
    .imem_rd_data (imem_rd_data),
    .imem_wr_en   (imem_wr_en),
    .imem_wr_addr (imem_wr_addr),
    .imem_wr_data (imem_wr_data),
    .core_hold    (core_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .fetch_err    (fetch_err)
  );

  // Memory model: combinational read, write on the clock edge; log every write.
  assign imem_rd_data = mem[imem_rd_addr];
  always @(posedge clk) begin
    if (imem_wr_en) begin
      mem[imem_wr_addr] <= imem_wr_data;
      wa.push_back(imem_wr_addr);
      wd.push_back(imem_wr_data);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int len);
    load_start = 1'b1;
    load_len   = LW'(len);
    tick();
    load_start = 1'b0;
  endtask

  // Feeds src[0..nb-1]; gap=1 offers a byte only on even cycles. Stops on
  // load_done (returns its cycle index relative to the first byte cycle),
  // after abort_at accepted bytes, or after a cycle budget (returns -1).
  task automatic feed(input int nb, input bit gap, input int abort_at,
                      input bit fetch_probe, output int done_cyc);
    int idx = 0;
    int cyc = 0;
    bit acc;
    done_cyc = -1;
    while (cyc < 200) begin
      if (abort_at >= 0 && idx == abort_at) break;
      byte_valid = (idx < nb) && (!gap || !cyc[0]);
      byte_data  = (idx < nb) ? src[idx] : 8'h00;
      acc = byte_valid && byte_ready;
      tick();
      cyc++;
      if (acc) idx++;
      if (fetch_probe && cyc == 6) begin
        chk("fetch_nop_during_load", fetch_data, NOP);
        chk("hold_during_load", 32'(core_hold), 32'd1);
      end
      if (imem_wr_en) chk("wr_after_4th_byte", 32'(idx > 0 && idx % 4 == 0 && !byte_ready), 32'd1);
      if (load_done) begin
        done_cyc = cyc;
        break;
      end
    end
    byte_valid = 1'b0;
  endtask

  function automatic logic [31:0] ctrl_outs();
    return 32'({byte_ready, imem_wr_en, core_hold, load_done, load_err});
  endfunction

  initial begin
    int dc;
    int n0;
    for (int i = 0; i < DEPTH; i++) mem[i] = FILL;
    fv[0] = '{32'h0000_0004, 32'hffff02b7, 1'b0};
    fv[1] = '{32'h0000_0000, 32'h00f00013, 1'b0};
    fv[2] = '{32'h0000_0008, FILL,         1'b0};
    fv[3] = '{32'h0000_0ffc, FILL,         1'b0};
    fv[4] = '{32'h0000_0002, NOP,          1'b1};
    fv[5] = '{32'h0000_1000, NOP,          1'b1};
    fv[6] = '{32'h8000_0000, NOP,          1'b1};

    rst = 1'b1; load_start = 1'b0; load_len = '0;
    byte_valid = 1'b0; byte_data = 8'h00; fetch_addr = 32'h0;
    repeat (3) tick();
    chk("reset_outputs", ctrl_outs(), 32'd0);
    rst = 1'b0;
    tick();

    // Two-word load with byte_valid held high.
    src[0] = 8'h13; src[1] = 8'h00; src[2] = 8'hf0; src[3] = 8'h00;
    src[4] = 8'hb7; src[5] = 8'h02; src[6] = 8'hff; src[7] = 8'hff;
    start(2);
    chk("hold_after_start", 32'(core_hold), 32'd1);
    feed(8, 1'b0, -1, 1'b1, dc);
    chk("done_latency_2w", dc, 10);
    tick();
    chk("hold_drop_after_done", 32'({core_hold, load_done}), 32'd0);
    chk("write_count_2w", wa.size(), 2);
    if (wa.size() == 2) begin
      chk("w0_addr", 32'(wa[0]), 32'd0);
      chk("w0_data", wd[0], 32'h00f00013);
      chk("w1_addr", 32'(wa[1]), 32'd1);
      chk("w1_data", wd[1], 32'hffff02b7);
    end

    for (int i = 0; i < 7; i++) begin
      fetch_addr = fv[i].addr;
      #1;
      chk($sformatf("fetch_data_%0d", i), fetch_data, fv[i].data);
      chk($sformatf("fetch_err_%0d", i), 32'(fetch_err), 32'(fv[i].err));
    end
    fetch_addr = 32'h0;

    // Illegal lengths.
    n0 = wa.size();
    start(0);
    chk("err_len0", 32'({load_err, core_hold, byte_ready}), 32'b100);
    start(1025);
    chk("err_len1025", 32'({load_err, core_hold, byte_ready}), 32'b100);
    tick();
    chk("err_no_write", wa.size(), n0);
    start(1024 + 0 * 1);
    chk("full_depth_accepted", 32'({load_err, core_hold}), 32'b01);
    rst = 1'b1; tick(); rst = 1'b0;
    start(1);
    chk("err_cleared", 32'({load_err, core_hold}), 32'b01);

    // One-word load with byte_valid toggling.
    n0 = wa.size();
    src[0] = 8'h78; src[1] = 8'h56; src[2] = 8'h34; src[3] = 8'h12;
    feed(4, 1'b1, -1, 1'b0, dc);
    chk("done_latency_gap", dc, 8);
    chk("write_count_gap", wa.size(), n0 + 1);
    if (wa.size() == n0 + 1) begin
      chk("gap_addr", 32'(wa[n0]), 32'd0);
      chk("gap_data", wd[n0], 32'h12345678);
    end
    tick();

    // Reset after two bytes of word 1 in a three-word load; rst beats load_start.
    n0 = wa.size();
    for (int i = 0; i < 12; i++) src[i] = 8'(8'h11 * (i + 1));
    start(3);
    feed(12, 1'b0, 6, 1'b0, dc);
    chk("abort_mid_rx", 32'(byte_ready), 32'd1);
    rst = 1'b1; load_start = 1'b1; load_len = LW'(1);
    tick();
    rst = 1'b0; load_start = 1'b0;
    chk("reset_mid_load_outputs", ctrl_outs(), 32'd0);
    repeat (3) tick();
    chk("still_idle_after_reset", ctrl_outs(), 32'd0);
    chk("abort_write_count", wa.size(), n0 + 1);
    if (wa.size() == n0 + 1) begin
      chk("abort_w0_addr", 32'(wa[n0]), 32'd0);
      chk("abort_w0_data", wd[n0], 32'h44332211);
    end

    // Fresh load restarts at address 0.
    n0 = wa.size();
    src[0] = 8'ha1; src[1] = 8'hb2; src[2] = 8'hc3; src[3] = 8'hd4;
    start(1);
    feed(4, 1'b0, -1, 1'b0, dc);
    chk("done_latency_1w", dc, 5);
    chk("restart_write_count", wa.size(), n0 + 1);
    if (wa.size() == n0 + 1) begin
      chk("restart_addr", 32'(wa[n0]), 32'd0);
      chk("restart_data", wd[n0], 32'hd4c3b2a1);
    end
    tick();
    fetch_addr = 32'h0;
    #1;
    chk("fetch_after_restart", fetch_data, 32'hd4c3b2a1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/risc_v_mike_imem_loader.md
Name: risc_v_mike_imem_loader

Overview:
- Controller that owns the instruction memory's write port and arbitrates it against core instruction fetch.
- Receives a program as a byte stream over a valid/ready handshake and packs it into little-endian 32-bit words.
- Writes each word to consecutive instruction-memory locations, holding the core (stall plus NOP injection) until the load completes.
- Sits between the byte source (UART/debug bridge), the instruction memory and the fetch stage.

Parameters:
- IMEM_DEPTH, 1024, number of 32-bit words in instruction memory.
- IMEM_ADDR_W, $clog2(IMEM_DEPTH), word-address width.
- LEN_W, IMEM_ADDR_W+1, width of load length field; must represent IMEM_DEPTH.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- load_len  in  LEN_W  number of words to load; sampled with load_start.
- byte_valid  in  1  byte source has data.
- byte_data  in  8  byte payload.
- byte_ready  out  1  loader accepts a byte this cycle.
- fetch_addr  in  32 (t_pc_addr)  core PC, byte address.
- fetch_data  out  32  instruction returned to core.
- imem_rd_addr  out  IMEM_ADDR_W  word read address to memory.
- imem_rd_data  in  32  memory read data, combinational.
- imem_wr_en  out  1  memory write strobe.
- imem_wr_addr  out  IMEM_ADDR_W  memory write word address.
- imem_wr_data  out  32  memory write data.
- core_hold  out  1  stall PC while high.
- load_done  out  1  one-cycle pulse at load completion.
- load_err  out  1  sticky: illegal load_len.
- fetch_err  out  1  combinational: misaligned or out-of-range fetch.

Behaviour:
- Reset: state IDLE, word_ptr 0, byte count 0, packed word 0; outputs byte_ready, imem_wr_en, core_hold, load_done and load_err all 0.
- States:
  - IDLE: when load_start is high, check load_len. If load_len is 0 or greater than IMEM_DEPTH, set load_err and stay in IDLE. Otherwise clear load_err, latch load_len, set word_ptr to 0 and go to RX.
  - RX: byte_ready=1. A byte is accepted on a rising edge with byte_valid&byte_ready and placed at bits [8*cnt+7:8*cnt]; byte 0 is the LSB. Accepting the 4th byte moves to WR.
  - WR: byte_ready=0. Drive imem_wr_en=1 for exactly one cycle, with imem_wr_addr=word_ptr and imem_wr_data=the packed word. Increment word_ptr and clear the byte count. If the incremented word_ptr equals load_len go to DONE, else go to RX.
  - DONE: load_done=1 for one cycle, then go to IDLE.
- core_hold is high in RX, WR and DONE; it is low the cycle after DONE.
- load_start outside IDLE is ignored.
- Throughput: minimum 5 cycles per word (4 byte cycles plus 1 write cycle); byte_valid gaps extend RX indefinitely; no timeout.
- Fetch path (combinational):
  - imem_rd_addr = fetch_addr[IMEM_ADDR_W+1:2].
  - fetch_err = (fetch_addr[1:0]!=0) | (fetch_addr>>2 >= IMEM_DEPTH).
  - fetch_data = NOP (32'h00000013) if core_hold or fetch_err, else imem_rd_data.
- Reset mid-load: return to IDLE immediately and discard the partial word. Words already written remain in memory; there is no rollback.
- Write-port ownership: the loader is the only writer; no write occurs outside WR.
- Boundaries:
  - load_len==IMEM_DEPTH writes addresses 0..IMEM_DEPTH-1; word_ptr never wraps.
  - load_start together with rst: rst wins.

Decomposition:
- risc_v_mike_pkg gains:
  - RV_NOP = 32'h00000013.
  - IMEM_DEPTH_DEF = 1024.
  - Enum t_imem_ld_state {LD_IDLE, LD_RX, LD_WR, LD_DONE}.
- Sub-module risc_v_mike_byte_packer: byte shift/packing register plus a 2-bit counter. Outputs word_full and word; has a clear input.

Test Plan:
- Load of 2 words, bytes 13,00,f0,00,b7,02,ff,ff with byte_valid held high:
  - writes 32'h00f00013 to addr 0, then 32'hffff02b7 to addr 1;
  - load_done pulses 10 cycles after the first byte;
  - core_hold drops the next cycle.
- During a load, fetch_addr=0 -> fetch_data=32'h00000013 and core_hold=1. After the load, fetch_addr=4 -> 32'hffff02b7.
- load_start with load_len=0, then with load_len=1025 -> load_err=1, no write, state stays IDLE. A following load_start with load_len=1 clears load_err.
- byte_valid toggling 1/0 every cycle during a 1-word load -> bytes are packed correctly and the write occurs only after the 4th accepted byte.
- rst after 2 bytes of word 1 in a 3-word load:
  - outputs return to their reset values;
  - word 0 stays in memory, word 1 is never written;
  - a new load then restarts at addr 0.
- fetch_addr=32'h2 -> fetch_err=1 and NOP; fetch_addr=32'h1000 (word 1024) -> fetch_err=1 and NOP.
